// File: rtl/vga_pkg.sv
// Shared timing constants, colour type and helpers for the VGA scan pipe.
package vga_pkg;

  // Standard 640x480@60 timing, in pixel clocks / lines.
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;

  localparam int unsigned H_TOTAL     = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned V_TOTAL     = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + DEF_H_ACTIVE - 1;
  localparam int unsigned V_ACT_START = DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + DEF_V_ACTIVE - 1;

  // ROM word layout {R4,G4,B4}.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Replicate the nibble so 4'hF maps to full scale 8'hFF.
  function automatic logic [7:0] expand4to8(input logic [3:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; reset loads every stage with i_rst_val.
module vga_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_rst_val,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_sr
      logic [DEPTH-1:0][W-1:0] r_sr;

      // Shift one stage per enable; reset flushes the whole line.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= i_rst_val;
        end else if (i_en) begin
          r_sr[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_pipe.sv
// VGA scan engine: h/v counters, ROM addressing, latency-matched sync/valid
// and 4->8 bit colour expansion with blanking.
module vga_scan_pipe
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [11:0] rom_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        frame_start,
  output logic        HS,
  output logic        VS,
  output logic        valid,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] H_SW    = 10'(H_SYNC);
  localparam logic [9:0] V_SW    = 10'(V_SYNC);

  logic [9:0] r_h_cnt, r_v_cnt;
  logic [9:0] r_h_addr, r_v_addr;
  logic       r_act0, r_hs0, r_vs0, r_frame_start;
  logic       w_h_act, w_v_act, w_act;
  logic [2:0] w_dly;
  rgb444_t    w_col;

  assign w_h_act = (r_h_cnt >= H_START) && (r_h_cnt <= H_END);
  assign w_v_act = (r_v_cnt >= V_START) && (r_v_cnt <= V_END);
  assign w_act   = w_h_act && w_v_act;

  // Raster counters; end of line and end of frame wrap on the same enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pix_en) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Stage 0: ROM address, raw active/sync flags and the frame marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_addr      <= '0;
      r_v_addr      <= '0;
      r_act0        <= 1'b0;
      r_hs0         <= 1'b1;
      r_vs0         <= 1'b1;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      r_h_addr      <= w_act ? r_h_cnt - H_START : '0;
      r_v_addr      <= w_act ? r_v_cnt - V_START : '0;
      r_act0        <= w_act;
      r_hs0         <= (r_h_cnt >= H_SW);
      r_vs0         <= (r_v_cnt >= V_SW);
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  vga_delay_line #(.DEPTH(RD_LAT), .W(3)) u_dly (
    .clk       (clk),
    .reset     (reset),
    .i_en      (pix_en),
    .i_rst_val (3'b011),
    .i_d       ({r_act0, r_hs0, r_vs0}),
    .o_q       (w_dly)
  );

  assign valid       = w_dly[2];
  assign HS          = w_dly[1];
  assign VS          = w_dly[0];
  assign h_addr      = r_h_addr;
  assign v_addr      = r_v_addr;
  assign frame_start = r_frame_start;

  // The colour register is the last ROM-read stage, so it lands on the same
  // enable as the delayed valid. With zero latency the ROM word is used as is.
  generate
    if (RD_LAT == 0) begin : g_col_comb
      assign w_col = rom_data;
    end else begin : g_col_reg
      rgb444_t r_col;

      // Capture the returned ROM word once per pixel.
      always_ff @(posedge clk) begin
        if (reset)       r_col <= '0;
        else if (pix_en) r_col <= rom_data;
      end

      assign w_col = r_col;
    end
  endgenerate

  // Blank to black outside the visible window.
  assign red   = valid ? expand4to8(w_col.r) : 8'h00;
  assign green = valid ? expand4to8(w_col.g) : 8'h00;
  assign blue  = valid ? expand4to8(w_col.b) : 8'h00;

endmodule

// File: tb/tb_vga_scan_pipe.sv
// Bench for vga_scan_pipe: full-size 640x480 instance plus a tiny-timing
// instance for frame wrap, checked against a closed-form scoreboard.
module tb_vga_scan_pipe;

  typedef struct packed {
    logic [9:0] ha;
    logic [9:0] va;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       vld;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  typedef struct packed {
    exp_t m;
    exp_t s;
  } pair_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  bit   rom_mode = 1'b0;

  logic [9:0]  m_ha, m_va, s_ha, s_va;
  logic        m_fs, m_hs, m_vs, m_vld, s_fs, s_hs, s_vs, s_vld;
  logic [7:0]  m_r, m_g, m_b, s_r, s_g, s_b;
  logic [11:0] m_rom, s_rom;

  // Model ROM: word derived from the address the DUT presents; the DUT's
  // colour register provides the single enable of read latency.
  assign m_rom = rom_mode ? 12'hFFF : {m_ha[3:0], m_va[3:0], 4'hA};
  assign s_rom = rom_mode ? 12'hFFF : {s_ha[3:0], s_va[3:0], 4'hA};

  vga_scan_pipe #(.RD_LAT(1)) u_main (
    .clk(clk), .reset(reset), .pix_en(pix_en), .rom_data(m_rom),
    .h_addr(m_ha), .v_addr(m_va), .frame_start(m_fs), .HS(m_hs), .VS(m_vs),
    .valid(m_vld), .red(m_r), .green(m_g), .blue(m_b)
  );

  // Small raster: 8 clocks per line, 7 lines per frame (56 enables).
  vga_scan_pipe #(
    .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .RD_LAT(1)
  ) u_small (
    .clk(clk), .reset(reset), .pix_en(pix_en), .rom_data(s_rom),
    .h_addr(s_ha), .v_addr(s_va), .frame_start(s_fs), .HS(s_hs), .VS(s_vs),
    .valid(s_vld), .red(s_r), .green(s_g), .blue(s_b)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    ecnt = 0;
  pair_t sb_q[$];

  // Expected outputs after n enables since reset. Stage 0 shows count n-1;
  // sync/valid/colour show count n-2 (one stage plus one enable of ROM latency).
  function automatic exp_t model(input int n, input int hsw, input int hbp,
                                 input int hac, input int hfp, input int vsw,
                                 input int vbp, input int vac, input int vfp,
                                 input bit ff);
    exp_t e;
    int ht, vt, c, h, v, ax, ay;
    logic [3:0] nx, ny;
    ht = hsw + hbp + hac + hfp;
    vt = vsw + vbp + vac + vfp;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (n >= 1) begin
      c = n - 1;
      h = c % ht;
      v = (c / ht) % vt;
      if (h >= hsw + hbp && h < hsw + hbp + hac && v >= vsw + vbp && v < vsw + vbp + vac) begin
        e.ha = 10'(h - hsw - hbp);
        e.va = 10'(v - vsw - vbp);
      end
      e.fs = (h == 0) && (v == 0);
    end
    if (n >= 2) begin
      c = n - 2;
      h = c % ht;
      v = (c / ht) % vt;
      e.hs = (h >= hsw);
      e.vs = (v >= vsw);
      e.vld = (h >= hsw + hbp && h < hsw + hbp + hac && v >= vsw + vbp && v < vsw + vbp + vac);
      if (e.vld) begin
        ax = h - hsw - hbp;
        ay = v - vsw - vbp;
        nx = 4'(ax);
        ny = 4'(ay);
        e.r = ff ? 8'hFF : {nx, nx};
        e.g = ff ? 8'hFF : {ny, ny};
        e.b = ff ? 8'hFF : 8'hAA;
      end
    end
    return e;
  endfunction

  function automatic exp_t pack(input logic [9:0] ha, input logic [9:0] va,
                                input logic fs, input logic hs, input logic vs,
                                input logic vld, input logic [7:0] r,
                                input logic [7:0] g, input logic [7:0] b);
    exp_t e;
    e.ha = ha; e.va = va; e.fs = fs; e.hs = hs; e.vs = vs; e.vld = vld;
    e.r = r; e.g = g; e.b = b;
    return e;
  endfunction

  // One clock: push expectations, advance, pop and compare both instances.
  task automatic step(input bit en);
    pair_t e;
    exp_t  gm, gs;
    pix_en = en;
    if (en) ecnt++;
    e.m = model(ecnt, 96, 48, 640, 16, 2, 33, 480, 10, rom_mode);
    e.s = model(ecnt, 2, 1, 4, 1, 2, 1, 3, 1, rom_mode);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    gm = pack(m_ha, m_va, m_fs, m_hs, m_vs, m_vld, m_r, m_g, m_b);
    gs = pack(s_ha, s_va, s_fs, s_hs, s_vs, s_vld, s_r, s_g, s_b);
    total++;
    if (gm !== e.m) begin
      bad++;
      $display("FAIL sb_main n=%0d got=%h exp=%h", ecnt, gm, e.m);
    end
    total++;
    if (gs !== e.s) begin
      bad++;
      $display("FAIL sb_small n=%0d got=%h exp=%h", ecnt, gs, e.s);
    end
  endtask

  task automatic do_reset(input bit en);
    pix_en = en;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ecnt = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    exp_t rv, gm, gs;
    rv = '0;
    rv.hs = 1'b1;
    rv.vs = 1'b1;
    do_reset(1'b0);
    gm = pack(m_ha, m_va, m_fs, m_hs, m_vs, m_vld, m_r, m_g, m_b);
    gs = pack(s_ha, s_va, s_fs, s_hs, s_vs, s_vld, s_r, s_g, s_b);
    total++;
    if (gm !== rv) begin bad++; $display("FAIL reset_main got=%h exp=%h", gm, rv); end
    total++;
    if (gs !== rv) begin bad++; $display("FAIL reset_small got=%h exp=%h", gs, rv); end
    // Idle clocks with pix_en low must not move anything.
    for (int i = 0; i < 4; i++) step(1'b0);
  endtask

  task automatic test_hsync_line();
    int lows, nfall, f0, f1;
    logic prev;
    do_reset(1'b0);
    lows = 0; nfall = 0; f0 = -1; f1 = -1; prev = 1'b1;
    for (int i = 0; i < 802; i++) begin
      step(1'b1);
      if (ecnt >= 2 && ecnt <= 801 && !m_hs) lows++;
      if (prev && !m_hs) begin
        if (nfall == 0) f0 = ecnt; else if (nfall == 1) f1 = ecnt;
        nfall++;
      end
      prev = m_hs;
    end
    total++;
    if (lows !== 96) begin bad++; $display("FAIL hs_low_width got=%0d exp=96", lows); end
    total++;
    if (f0 !== 2) begin bad++; $display("FAIL hs_first_fall got=%0d exp=2", f0); end
    total++;
    if (f1 !== 802) begin bad++; $display("FAIL hs_line_period got=%0d exp=802", f1); end
  endtask

  task automatic test_small_frame();
    int fs_cnt, vld_cnt, vs_low;
    do_reset(1'b0);
    fs_cnt = 0; vld_cnt = 0; vs_low = 0;
    for (int i = 0; i < 112; i++) begin
      step(1'b1);
      if (s_fs) fs_cnt++;
      if (ecnt >= 2 && ecnt <= 57) begin
        if (s_vld) vld_cnt++;
        if (!s_vs) vs_low++;
      end
    end
    total++;
    if (fs_cnt !== 2) begin bad++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
    total++;
    if (vld_cnt !== 12) begin bad++; $display("FAIL small_valid_count got=%0d exp=12", vld_cnt); end
    total++;
    if (vs_low !== 16) begin bad++; $display("FAIL small_vs_low got=%0d exp=16", vs_low); end
  endtask

  task automatic test_blanking();
    int viol, ffs;
    rom_mode = 1'b1;
    do_reset(1'b0);
    viol = 0; ffs = 0;
    for (int i = 0; i < 112; i++) begin
      step(1'b1);
      if (s_vld && {s_r, s_g, s_b} == 24'hFFFFFF && ecnt <= 57) ffs++;
      if (!s_vld && {s_r, s_g, s_b} != 24'h0) viol++;
      if (!m_vld && {m_r, m_g, m_b} != 24'h0) viol++;
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL blank_leak got=%0d exp=0", viol); end
    total++;
    if (ffs !== 12) begin bad++; $display("FAIL white_pixels got=%0d exp=12", ffs); end
    rom_mode = 1'b0;
  endtask

  task automatic test_first_pixel();
    do_reset(1'b0);
    while (ecnt < 28145) step(1'b1);
    total++;
    if (m_vld !== 1'b0) begin bad++; $display("FAIL pre_visible_valid got=%b exp=0", m_vld); end
    step(1'b1);
    total++;
    if ({m_vld, m_r, m_g, m_b} !== {1'b1, 24'h0000AA}) begin
      bad++;
      $display("FAIL first_pixel got vld=%b rgb=%h exp vld=1 rgb=0000aa", m_vld, {m_r, m_g, m_b});
    end
  endtask

  // Reset in the middle of a visible line (h_cnt=500, line 35).
  task automatic test_mid_reset();
    while (ecnt < 28500) step(1'b1);
    total++;
    if (m_vld !== 1'b1) begin bad++; $display("FAIL mid_line_valid got=%b exp=1", m_vld); end
    do_reset(1'b1);
    total++;
    if ({m_hs, m_vs, m_vld, m_fs, m_ha, m_r, m_g, m_b} !== {4'b1100, 10'd0, 24'h0}) begin
      bad++;
      $display("FAIL mid_reset got hs=%b vs=%b vld=%b fs=%b ha=%0d rgb=%h exp hs=1 vs=1 vld=0 fs=0 ha=0 rgb=000000",
               m_hs, m_vs, m_vld, m_fs, m_ha, {m_r, m_g, m_b});
    end
    step(1'b1);
    total++;
    if ({m_fs, s_fs} !== 2'b11) begin
      bad++;
      $display("FAIL restart_frame_start got=%b%b exp=11", m_fs, s_fs);
    end
  endtask

  task automatic test_half_rate();
    int nfall, c0, c1;
    logic prev;
    do_reset(1'b0);
    nfall = 0; c0 = -1; c1 = -1; prev = 1'b1;
    for (int i = 0; i < 3400; i++) begin
      step(i % 2 == 0);
      if (prev && !m_hs) begin
        if (nfall == 0) c0 = i; else if (nfall == 1) c1 = i;
        nfall++;
      end
      prev = m_hs;
    end
    total++;
    if (c1 - c0 !== 1600) begin
      bad++;
      $display("FAIL half_rate_line got=%0d exp=1600", c1 - c0);
    end
  endtask

  initial begin
    test_reset();
    test_hsync_line();
    test_small_frame();
    test_blanking();
    test_first_pixel();
    test_mid_reset();
    test_half_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
